ram_1w1r_rr_arb: RTL
====================

Name: ram_1w1r_rr_arb

Overview:
- Single-clock round-robin arbiter that shares one 1Kx36 simple-dual-port block RAM (1 write port, 1 read port, both ports in the same clock domain) between num_req requesters.
- Write port and read port are arbitrated independently; at most one write and one read are issued per cycle.
- Tracks the fixed read-pipeline latency, steers returned data to the requester that issued the read, and blocks the same-address same-cycle read/write hazard.

Parameters:
- num_req, 4, number of requesters (2..8).
- depth_bits, 10, RAM address width.
- width_bits, 36, RAM data width.
- sleep_idle_cycles, 16, consecutive idle cycles before sleep is asserted (optional feature only).

Ports:
- clk  in  1  sole clock; also drives both RAM clocks.
- reset_n  in  1  asynchronous, active-low reset.
- wr_req  in  num_req  per-requester write request; held until granted.
- wr_addr  in  num_req*depth_bits  flattened write addresses; requester i at slice i.
- wr_data  in  num_req*width_bits  flattened write data.
- wr_gnt  out  num_req  combinational one-hot write grant; transfer = wr_req[i] & wr_gnt[i] at the clock edge.
- rd_req  in  num_req  per-requester read request.
- rd_addr  in  num_req*depth_bits  flattened read addresses.
- rd_gnt  out  num_req  combinational one-hot read grant.
- rd_vld  out  num_req  one-hot return strobe.
- rd_data  out  width_bits  returned read data; valid when any rd_vld bit is 1.
- ram_sleep  out  1  RAM sleep control.
- ram_a_en  out  1  RAM write-port enable.
- ram_a_we  out  1  RAM write enable.
- ram_a_addr  out  depth_bits  RAM write address.
- ram_a_di  out  width_bits  RAM write data.
- ram_b_en  out  1  RAM read-port enable.
- ram_b_addr  out  depth_bits  RAM read address.
- ram_b_do  in  width_bits  RAM read data.

Behaviour:
- Reset values:
  - wr_gnt, rd_gnt, rd_vld: 0.
  - rd_data: 0.
  - ram_a_we: 0.
  - ram_a_addr, ram_a_di, ram_b_addr: 0.
  - ram_a_en, ram_b_en: 1.
  - ram_sleep: 0.
  - Both round-robin pointers: 0.
  - Return tag pipeline: cleared.
- Arbitration, applied separately to the write side and the read side:
  - The winner is the lowest index at or after the pointer, wrapping modulo num_req.
  - After a transfer, the pointer becomes winner+1, wrapping from num_req-1 to 0.
  - With no request, the grant is 0 and the pointer holds.
  - Grants depend only on current requests and the registered pointers; there are no combinational paths from ram_b_do.
- Issue registers:
  - The winning write's addr and data are registered onto ram_a_addr and ram_a_di, with ram_a_we=1 for exactly one cycle.
  - The winning read's addr is registered onto ram_b_addr.
  - ram_a_we=0 in cycles with no write transfer.
- Latency:
  - Write: a handshake at edge E0 becomes visible in the array at E2.
  - Read: a handshake at edge E0 makes rd_vld[i] and rd_data valid for the single cycle following edge E3.
  - Tag pipeline: 3-stage shift of {valid, id}; rd_data is registered from ram_b_do, or rd_data = ram_b_do aligned to stage 3.
- Throughput: one read per cycle sustained; returns stay in issue order.
- Hazard rule:
  - Condition: the read-side winner's address equals the write-side winner's address in the same cycle.
  - Action: all rd_gnt are forced to 0 that cycle and the read pointer does not advance. The write proceeds.
  - The read is granted the next cycle and returns the new data.
  - A read one cycle after a same-address write needs no stall.
- Boundaries:
  - A single requester can transfer every cycle.
  - All requesters active: grants rotate 0,1,2,3,0,...
  - wr_req and rd_req from the same requester in the same cycle are independent and both may be granted.
- Asynchronous reset mid-operation: in-flight reads are discarded (no rd_vld) and queued writes are dropped. Writes already registered into the RAM may or may not commit.

Optional Feature:
- Macro: RAM_ARB_SLEEP_EN.
- With the macro:
  - An idle counter counts cycles with no wr_req, no rd_req, no tag-pipeline entry valid and ram_a_we=0.
  - When it reaches sleep_idle_cycles, ram_sleep=1 and ram_a_en/ram_b_en=0.
  - Any request while asleep: ram_sleep drops the next cycle, all grants stay 0 during that wake cycle, and grants resume the cycle after.
  - Sleep is never asserted while reads are in flight.
- Without the macro: ram_sleep is tied to 0 and the enables are tied to 1; there is no idle counter.

Decomposition:
- Shared package ram_arb_pkg: default depth_bits/width_bits, RD_LAT=3, and the max num_req constant.
- One sub-module, rr_arb_pick (requests, pointer -> one-hot grant and winner index), instantiated twice: once for writes, once for reads.

Test Plan:
- Requester 1 writes addr 0x005 = 0x9_ABCD_0123, then reads 0x005 two cycles later -> rd_vld=4'b0010 exactly 3 cycles after the read handshake, rd_data = 0x9_ABCD_0123.
- All four rd_req held high for 8 cycles, addrs 0x010..0x013 preloaded with 0x10..0x13 -> rd_gnt rotates 0001,0010,0100,1000 repeating; rd_vld and data follow in the same order, one per cycle.
- Write 0x3FF=0x1 by requester 0 and read 0x3FF by requester 2 in the same cycle, with old value 0x0 -> wr_gnt=0001, rd_gnt=0 that cycle; read granted next cycle and returns 0x1.
- Pointer wrap: only requester 3 then requester 0 request writes -> grants 1000 then 0001; ram_a_we high for exactly 2 cycles.
- reset_n pulsed low with 2 reads in flight -> no rd_vld after release; all outputs at reset values while reset_n=0.
- RAM_ARB_SLEEP_EN defined: 16 idle cycles -> ram_sleep=1; then rd_req[0]=1 -> sleep drops, rd_gnt[0]=0 for 1 cycle, then granted; data correct.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Package  : ram_arb_pkg
// Brief    : Shared constants and types for the 1W1R round-robin RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int c_DEPTH_BITS  = 10;
  localparam int c_WIDTH_BITS  = 36;
  localparam int c_RD_LAT      = 3;
  localparam int c_MAX_NUM_REQ = 8;

  typedef logic [$clog2(c_MAX_NUM_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_pick.sv
// ============================================================================
// Module   : rr_arb_pick
// Brief    : Combinational round-robin pick: lowest requester at or after the
//            pointer, wrapping, as a one-hot grant plus the winner index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_vld
);

  // Second scan overrides the first, so a hit at/after the pointer beats a wrapped one.
  always_comb begin
    o_idx = '0;
    o_vld = |i_req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i] && (i < int'(i_ptr))) o_idx = IDX_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i] && (i >= int'(i_ptr))) o_idx = IDX_W'(i);
    end
    o_gnt = o_vld ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/ram_1w1r_rr_arb.sv
// ============================================================================
// Module   : ram_1w1r_rr_arb
// Brief    : Shares one simple-dual-port BRAM (registered read output) between
//            NUM_REQ requesters with independent round-robin write/read arbiters.
// Options  : RAM_ARB_SLEEP_EN - idle counter drives ram_sleep and port enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_1w1r_rr_arb
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int DEPTH_BITS        = c_DEPTH_BITS,
  parameter int WIDTH_BITS        = c_WIDTH_BITS,
  parameter int SLEEP_IDLE_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               wr_req,
  input  logic [NUM_REQ*DEPTH_BITS-1:0]    wr_addr,
  input  logic [NUM_REQ*WIDTH_BITS-1:0]    wr_data,
  output logic [NUM_REQ-1:0]               wr_gnt,
  input  logic [NUM_REQ-1:0]               rd_req,
  input  logic [NUM_REQ*DEPTH_BITS-1:0]    rd_addr,
  output logic [NUM_REQ-1:0]               rd_gnt,
  output logic [NUM_REQ-1:0]               rd_vld,
  output logic [WIDTH_BITS-1:0]            rd_data,
  output logic                             ram_sleep,
  output logic                             ram_a_en,
  output logic                             ram_a_we,
  output logic [DEPTH_BITS-1:0]            ram_a_addr,
  output logic [WIDTH_BITS-1:0]            ram_a_di,
  output logic                             ram_b_en,
  output logic [DEPTH_BITS-1:0]            ram_b_addr,
  input  logic [WIDTH_BITS-1:0]            ram_b_do
);

  localparam int c_IDX_W = idx_width(NUM_REQ);

  logic [DEPTH_BITS-1:0] w_wr_addr_arr [NUM_REQ];
  logic [WIDTH_BITS-1:0] w_wr_data_arr [NUM_REQ];
  logic [DEPTH_BITS-1:0] w_rd_addr_arr [NUM_REQ];

  logic [NUM_REQ-1:0]    w_wr_pick_gnt, w_rd_pick_gnt;
  logic [c_IDX_W-1:0]    w_wr_idx, w_rd_idx, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic                  w_wr_vld, w_rd_vld, w_hazard, w_grant_en;
  logic                  w_wr_xfer, w_rd_xfer;

  logic [c_IDX_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic                  r_a_we;
  logic [DEPTH_BITS-1:0] r_a_addr, r_b_addr;
  logic [WIDTH_BITS-1:0] r_a_di, r_rd_data;
  logic [NUM_REQ-1:0]    r_rd_vld;
  rd_tag_t               r_tag [c_RD_LAT];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_wr_addr_arr[gi] = wr_addr[gi*DEPTH_BITS +: DEPTH_BITS];
      assign w_wr_data_arr[gi] = wr_data[gi*WIDTH_BITS +: WIDTH_BITS];
      assign w_rd_addr_arr[gi] = rd_addr[gi*DEPTH_BITS +: DEPTH_BITS];
    end
  endgenerate

  rr_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(c_IDX_W)) u_wr_pick (
    .i_req (wr_req),
    .i_ptr (r_wr_ptr),
    .o_gnt (w_wr_pick_gnt),
    .o_idx (w_wr_idx),
    .o_vld (w_wr_vld)
  );

  rr_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(c_IDX_W)) u_rd_pick (
    .i_req (rd_req),
    .i_ptr (r_rd_ptr),
    .o_gnt (w_rd_pick_gnt),
    .o_idx (w_rd_idx),
    .o_vld (w_rd_vld)
  );

  // A same-cycle same-address read would see stale data in the BRAM, so it waits a cycle.
  assign w_hazard = w_wr_vld & w_rd_vld & (w_wr_addr_arr[w_wr_idx] == w_rd_addr_arr[w_rd_idx]);

  assign wr_gnt    = w_grant_en ? w_wr_pick_gnt : '0;
  assign rd_gnt    = (w_grant_en & ~w_hazard) ? w_rd_pick_gnt : '0;
  assign w_wr_xfer = |wr_gnt;
  assign w_rd_xfer = |rd_gnt;

  assign w_wr_ptr_nxt = (w_wr_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_wr_idx + 1'b1;
  assign w_rd_ptr_nxt = (w_rd_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_rd_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_a_we   <= 1'b0;
      r_a_addr <= '0;
      r_a_di   <= '0;
      r_b_addr <= '0;
    end else begin
      r_a_we <= w_wr_xfer;
      if (w_wr_xfer) begin
        r_a_addr <= w_wr_addr_arr[w_wr_idx];
        r_a_di   <= w_wr_data_arr[w_wr_idx];
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_xfer) begin
        r_b_addr <= w_rd_addr_arr[w_rd_idx];
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

  // Tag travels alongside the BRAM read pipe; the final stage lines up with ram_b_do.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < c_RD_LAT; s++) r_tag[s] <= '0;
      r_rd_vld  <= '0;
      r_rd_data <= '0;
    end else begin
      r_tag[0].vld <= w_rd_xfer;
      r_tag[0].id  <= req_id_t'(w_rd_idx);
      for (int s = 1; s < c_RD_LAT; s++) r_tag[s] <= r_tag[s-1];
      r_rd_vld <= r_tag[c_RD_LAT-1].vld ? (NUM_REQ'(1) << r_tag[c_RD_LAT-1].id) : '0;
      if (r_tag[c_RD_LAT-1].vld) r_rd_data <= ram_b_do;
    end
  end

`ifdef RAM_ARB_SLEEP_EN
  localparam int c_CNT_W = $clog2(SLEEP_IDLE_CYCLES + 1);

  logic [c_CNT_W-1:0] r_idle_cnt;
  logic               r_sleep;
  logic               w_tag_busy, w_idle;

  always_comb begin
    w_tag_busy = 1'b0;
    for (int s = 0; s < c_RD_LAT; s++) w_tag_busy = w_tag_busy | r_tag[s].vld;
  end

  assign w_idle = ~(|wr_req) & ~(|rd_req) & ~w_tag_busy & ~r_a_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
      r_sleep    <= 1'b0;
    end else if (!w_idle) begin
      r_idle_cnt <= '0;
      r_sleep    <= 1'b0;
    end else if (r_idle_cnt != c_CNT_W'(SLEEP_IDLE_CYCLES)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
      if (r_idle_cnt == c_CNT_W'(SLEEP_IDLE_CYCLES - 1)) r_sleep <= 1'b1;
    end
  end

  // Grants stay off for the wake cycle while the RAM comes out of sleep.
  assign w_grant_en = reset_n & ~r_sleep;
  assign ram_sleep  = r_sleep;
  assign ram_a_en   = ~r_sleep;
  assign ram_b_en   = ~r_sleep;
`else
  assign w_grant_en = reset_n;
  assign ram_sleep  = 1'b0;
  assign ram_a_en   = 1'b1;
  assign ram_b_en   = 1'b1;
`endif

  assign ram_a_we   = r_a_we;
  assign ram_a_addr = r_a_addr;
  assign ram_a_di   = r_a_di;
  assign ram_b_addr = r_b_addr;
  assign rd_vld     = r_rd_vld;
  assign rd_data    = r_rd_data;

endmodule

`default_nettype wire
